// File: rtl/multu_seq_if.sv
// Request/response bundle between the CPU pipeline and the MULTU/MADDU
// shift-add multiplier.
//   master : pipeline side, issues start/operands and watches busy/result
//   slave  : multiplier side
interface multu_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 isMADDU;
    logic [WIDTH-1:0]     opA;
    logic [WIDTH-1:0]     opB;
    logic                 busy;
    logic [2*WIDTH-1:0]   MULAns;
    logic                 MULTU;
    logic                 MADDU;

    modport master (
        output start, isMADDU, opA, opB,
        input  busy, MULAns, MULTU, MADDU
    );

    modport slave (
        input  start, isMADDU, opA, opB,
        output busy, MULAns, MULTU, MADDU
    );
endinterface

// File: rtl/multu_seq.sv
// Iterative shift-add unsigned multiplier feeding the Hi/Lo register block.
// Retires BPC multiplier bits per clock; a WIDTH x WIDTH product takes
// WIDTH/BPC busy cycles and ends with a one-cycle MULTU or MADDU strobe
// that lines up with the new MULAns value.
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero instead of always running WIDTH/BPC steps.
module multu_seq #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic        clk,
    input  logic        reset,
    multu_seq_if.slave  bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   accNext;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mplierNext;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cntNext;
    logic                 flag;
    logic                 done;

    // One multiply step: add the shifted multiplicand for each of the BPC low
    // multiplier bits, and decide whether this step is the final one.
    always_comb begin
        accNext = acc;
        for (int i = 0; i < BPC; i++) begin
            if (mplier[i]) begin
                accNext = accNext + (mcand << i);
            end
        end
        mplierNext = mplier >> BPC;
        cntNext    = cnt - CW'(1);
`ifdef MUL_EARLY_EXIT_EN
        done = (cntNext == '0) || (mplierNext == '0);
`else
        done = (cntNext == '0);
`endif
    end

    // Control FSM plus datapath registers; strobes default low so they last
    // exactly one cycle after each completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            flag       <= 1'b0;
            bus.busy   <= 1'b0;
            bus.MULAns <= '0;
            bus.MULTU  <= 1'b0;
            bus.MADDU  <= 1'b0;
        end else begin
            bus.MULTU <= 1'b0;
            bus.MADDU <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand    <= {{WIDTH{1'b0}}, bus.opA};
                        mplier   <= bus.opB;
                        acc      <= '0;
                        cnt      <= CW'(N);
                        flag     <= bus.isMADDU;
                        bus.busy <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= accNext;
                    mcand  <= mcand << BPC;
                    mplier <= mplierNext;
                    cnt    <= cntNext;
                    if (done) begin
                        bus.MULAns <= accNext;
                        bus.busy   <= 1'b0;
                        bus.MULTU  <= ~flag;
                        bus.MADDU  <= flag;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed cases plus randomized
// operands compared against a plain-arithmetic product and latency model.
module tb_multu_seq;
    localparam int WIDTH = 32;
    localparam int BPC   = 1;
    localparam int N     = WIDTH / BPC;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    multu_seq_if #(.WIDTH(WIDTH)) bus ();

    multu_seq #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck design still ends the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: expected busy cycles for a given multiplier
    function automatic int expLat(logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int len;
        int steps;
        len = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) len = i + 1;
        end
        steps = (len + BPC - 1) / BPC;
        if (steps < 1) steps = 1;
        return steps;
`else
        return N;
`endif
    endfunction

    // Reference: full-width unsigned product
    function automatic logic [2*WIDTH-1:0] expProd(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] wa;
        logic [2*WIDTH-1:0] wb;
        wa = {{WIDTH{1'b0}}, a};
        wb = {{WIDTH{1'b0}}, b};
        return wa * wb;
    endfunction

    // Pulse start for one edge from a negedge; scramble operands afterwards
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m);
        bus.opA     = a;
        bus.opB     = b;
        bus.isMADDU = m;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.opA     = $urandom;
        bus.opB     = $urandom;
        bus.isMADDU = $urandom_range(0, 1);
    endtask

    // Count busy cycles until completion, bounded
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (bus.busy !== 1'b0 || bus.MULAns !== '0 || bus.MULTU !== 1'b0 || bus.MADDU !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_hold: busy=%b MULAns=%h MULTU=%b MADDU=%b want all 0",
                         bus.busy, bus.MULAns, bus.MULTU, bus.MADDU);
            end
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            tests++;
            if (bus.busy !== 1'b0 || bus.MULAns !== '0 || bus.MULTU !== 1'b0 || bus.MADDU !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_idle: busy=%b MULAns=%h MULTU=%b MADDU=%b want all 0",
                         bus.busy, bus.MULAns, bus.MULTU, bus.MADDU);
            end
        end
    endtask

    task automatic test_multu();
        int cyc;
        applyStimulus(32'h3, 32'h5, 1'b0);
        waitDone(cyc);
        tests++;
        if (cyc !== expLat(32'h5)) begin
            fails++;
            $display("[TB] FAIL multu_latency: got %0d want %0d", cyc, expLat(32'h5));
        end
        tests++;
        if (bus.MULAns !== 64'hF || bus.MULTU !== 1'b1 || bus.MADDU !== 1'b0) begin
            fails++;
            $display("[TB] FAIL multu_result: MULAns=%h MULTU=%b MADDU=%b want %h 1 0",
                     bus.MULAns, bus.MULTU, bus.MADDU, 64'hF);
        end
        @(negedge clk);
        tests++;
        if (bus.MULTU !== 1'b0 || bus.MADDU !== 1'b0 || bus.MULAns !== 64'hF) begin
            fails++;
            $display("[TB] FAIL multu_strobe_drop: MULTU=%b MADDU=%b MULAns=%h want 0 0 %h",
                     bus.MULTU, bus.MADDU, bus.MULAns, 64'hF);
        end
    endtask

    task automatic test_maddu();
        int cyc;
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        waitDone(cyc);
        tests++;
        if (cyc !== expLat(32'hFFFFFFFF)) begin
            fails++;
            $display("[TB] FAIL maddu_latency: got %0d want %0d", cyc, expLat(32'hFFFFFFFF));
        end
        tests++;
        if (bus.MULAns !== 64'hFFFFFFFE00000001 || bus.MADDU !== 1'b1 || bus.MULTU !== 1'b0) begin
            fails++;
            $display("[TB] FAIL maddu_result: MULAns=%h MADDU=%b MULTU=%b want %h 1 0",
                     bus.MULAns, bus.MADDU, bus.MULTU, 64'hFFFFFFFE00000001);
        end
        @(negedge clk);
        tests++;
        if (bus.MADDU !== 1'b0 || bus.MULTU !== 1'b0) begin
            fails++;
            $display("[TB] FAIL maddu_strobe_drop: MADDU=%b MULTU=%b want 0 0", bus.MADDU, bus.MULTU);
        end
    endtask

    task automatic test_ignore_busy();
        int cyc;
        int k;
        int strobes;
        k = (expLat(32'h6) > 5) ? 4 : 1;
        applyStimulus(32'h7, 32'h6, 1'b0);
        repeat (k) @(negedge clk);
        bus.opA     = 32'h2;
        bus.opB     = 32'h2;
        bus.isMADDU = 1'b1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        waitDone(cyc);
        tests++;
        if (cyc + k + 1 !== expLat(32'h6)) begin
            fails++;
            $display("[TB] FAIL ignore_latency: got %0d want %0d", cyc + k + 1, expLat(32'h6));
        end
        tests++;
        if (bus.MULAns !== 64'h2A || bus.MULTU !== 1'b1 || bus.MADDU !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ignore_result: MULAns=%h MULTU=%b MADDU=%b want %h 1 0",
                     bus.MULAns, bus.MULTU, bus.MADDU, 64'h2A);
        end
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.MULTU !== 1'b0 || bus.MADDU !== 1'b0) strobes++;
        end
        tests++;
        if (strobes !== 0 || bus.MULAns !== 64'h2A) begin
            fails++;
            $display("[TB] FAIL ignore_no_queue: activity=%0d MULAns=%h want 0 %h", strobes, bus.MULAns, 64'h2A);
        end
    endtask

    task automatic test_reset_abort();
        int k;
        int cyc;
        k = (expLat(32'h10) > 10) ? 9 : 2;
        applyStimulus(32'h10, 32'h10, 1'b0);
        repeat (k) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.MULAns !== '0 || bus.MULTU !== 1'b0 || bus.MADDU !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_state: busy=%b MULAns=%h MULTU=%b MADDU=%b want all 0",
                     bus.busy, bus.MULAns, bus.MULTU, bus.MADDU);
        end
        repeat (N + 2) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.MULAns !== '0 || bus.MULTU !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_quiet: busy=%b MULAns=%h MULTU=%b want 0 0 0", bus.busy, bus.MULAns, bus.MULTU);
        end
        applyStimulus(32'h9, 32'h9, 1'b0);
        waitDone(cyc);
        tests++;
        if (cyc !== expLat(32'h9) || bus.MULAns !== 64'h51 || bus.MULTU !== 1'b1) begin
            fails++;
            $display("[TB] FAIL abort_rerun: cycles=%0d MULAns=%h MULTU=%b want %0d %h 1",
                     cyc, bus.MULAns, bus.MULTU, expLat(32'h9), 64'h51);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [WIDTH-1:0] a2;
        logic [WIDTH-1:0] b2;
        applyStimulus(32'h12345678, 32'h1, 1'b0);
        waitDone(cyc);
        tests++;
        if (cyc !== expLat(32'h1) || bus.MULAns !== 64'h0000000012345678 || bus.MULTU !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_first: cycles=%0d MULAns=%h MULTU=%b want %0d %h 1",
                     cyc, bus.MULAns, bus.MULTU, expLat(32'h1), 64'h12345678);
        end
        a2 = $urandom;
        b2 = $urandom | 32'h1;
        applyStimulus(a2, b2, 1'b1);
        tests++;
        if (bus.busy !== 1'b1 || bus.MULTU !== 1'b0 || bus.MADDU !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_accept: busy=%b MULTU=%b MADDU=%b want 1 0 0", bus.busy, bus.MULTU, bus.MADDU);
        end
        waitDone(cyc);
        tests++;
        if (cyc !== expLat(b2) || bus.MULAns !== expProd(a2, b2) || bus.MADDU !== 1'b1 || bus.MULTU !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_second: cycles=%0d MULAns=%h MADDU=%b MULTU=%b want %0d %h 1 0",
                     cyc, bus.MULAns, bus.MADDU, bus.MULTU, expLat(b2), expProd(a2, b2));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic m;
        for (int n = 0; n < 16; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            m = $urandom_range(0, 1);
            applyStimulus(a, b, m);
            waitDone(cyc);
            tests++;
            if (cyc !== expLat(b)) begin
                fails++;
                $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", n, cyc, expLat(b));
            end
            tests++;
            if (bus.MULAns !== expProd(a, b) || bus.MADDU !== m || bus.MULTU !== ~m) begin
                fails++;
                $display("[TB] FAIL rand_result[%0d]: a=%h b=%h MULAns=%h MULTU=%b MADDU=%b want %h %b %b",
                         n, a, b, bus.MULAns, bus.MULTU, bus.MADDU, expProd(a, b), ~m, m);
            end
            @(negedge clk);
            tests++;
            if (bus.MULTU !== 1'b0 || bus.MADDU !== 1'b0 || bus.MULAns !== expProd(a, b)) begin
                fails++;
                $display("[TB] FAIL rand_hold[%0d]: MULTU=%b MADDU=%b MULAns=%h want 0 0 %h",
                         n, bus.MULTU, bus.MADDU, bus.MULAns, expProd(a, b));
            end
        end
    endtask

    // Test sequence
    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.isMADDU = 1'b0;
        bus.opA     = '0;
        bus.opB     = '0;
        test_reset();
        test_multu();
        test_maddu();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
